// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_t    : controller states (IDLE, SHIFT, DONE)
//   - DIGIT_W    : bits per BCD digit
//   - ADJ_THRESH : digit value at or above which the +3 adjust is applied
//   - minDigits  : smallest digit count able to hold 2^width-1, used by the
//                  top level to reject an undersized DIGITS at elaboration
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;

    // Count decimal digits of the largest unsigned value of the given width.
    function automatic int minDigits(input int width);
        int value;
        int count;
        value = (1 << width) - 1;
        count = 0;
        do begin
            count = count + 1;
            value = value / 10;
        end while (value > 0);
        return count;
    endfunction

endpackage

// File: rtl/bcd_conv_ctrl_dd_adj3.sv
// ---------------------------------------------------------------------------
// dd_adj3
// One double-dabble digit-adjust cell: a digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decimal digit.
// Purely combinational, no carry out of the digit.
// Ports:
//   i_digit  [3:0]  scratch digit before adjust
//   o_digit  [3:0]  adjusted digit
// ---------------------------------------------------------------------------
module dd_adj3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // Conditional +3; legal digits are 0..9 so the sum never exceeds 12.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= DIGIT_W'(ADJ_THRESH)) begin
            o_digit = i_digit + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_conv_ctrl
// Sequential binary-to-BCD converter. An accepted start latches bin, then the
// shift-and-add-3 algorithm runs one bit per clock through a single row of
// dd_adj3 cells. The result is registered and held until the next done.
// Parameters:
//   WIDTH   binary input width (4..16)
//   DIGITS  BCD digits produced, must satisfy 10^DIGITS > 2^WIDTH-1
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  conversion request, only honoured while not busy
//   bin    unsigned value, captured with an accepted start
//   busy   conversion in progress
//   done   one-cycle pulse, bcd (and blank) just updated
//   bcd    result, digit 0 (ones) in [3:0]
//   blank  leading-zero flags, bit i for digit i
// Configuration macro:
//   BCD_LZB_EN  when defined, blank is a registered leading-zero mask;
//               otherwise blank is tied to 0 and no blanking logic exists.
// ---------------------------------------------------------------------------
module bcd_conv_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]         blank
);

    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Reject configurations the algorithm cannot convert exactly.
    generate
        if ((WIDTH < 4) || (WIDTH > 16) || (DIGITS < minDigits(WIDTH))) begin : g_paramCheck
            $error("bcd_conv_ctrl: illegal WIDTH/DIGITS combination");
        end
    endgenerate

    state_t             r_state;
    state_t             w_stateNext;
    logic [WIDTH-1:0]   r_sreg;
    logic [SCR_W-1:0]   r_scr;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCR_W-1:0]   r_bcd;
    logic               w_load;
    logic               w_shiftEn;
    logic               w_finish;
    logic [SCR_W-1:0]   w_scrAdj;
    logic [SCR_W+WIDTH-1:0] w_shifted;
    logic [SCR_W-1:0]   w_scrNext;
    logic [WIDTH-1:0]   w_sregNext;

    // One adjust cell per digit; digits never exchange carries.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            dd_adj3 u_adj (
                .i_digit (r_scr[g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_scrAdj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Adjusted scratch and the remaining binary bits shift left as one word,
    // so the binary MSB moves into the ones digit each cycle.
    assign w_shifted  = {w_scrAdj, r_sreg} << 1;
    assign w_scrNext  = w_shifted[SCR_W+WIDTH-1:WIDTH];
    assign w_sregNext = w_shifted[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and control decode. A start is accepted from IDLE and also
    // from DONE, which lets a held start run conversions back to back.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_shiftEn   = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                w_shiftEn = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_finish    = 1'b1;
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_stateNext = SHIFT;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Shift datapath: load on an accepted start, then one bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
            r_scr  <= '0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_sreg <= bin;
            r_scr  <= '0;
            r_cnt  <= CNT_W'(WIDTH);
        end else if (w_shiftEn) begin
            r_sreg <= w_sregNext;
            r_scr  <= w_scrNext;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Result register takes the post-shift scratch on the final shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd <= '0;
        end else if (w_finish) begin
            r_bcd <= w_scrNext;
        end
    end

`ifdef BCD_LZB_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blankNext;
    logic              w_allZero;

    // Walk down from the top digit; a digit blanks while everything above it
    // (and itself) is zero. The ones digit is always shown.
    always_comb begin
        w_blankNext = '0;
        w_allZero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_allZero      = w_allZero && (w_scrNext[i*DIGIT_W +: DIGIT_W] == '0);
            w_blankNext[i] = w_allZero;
        end
    end

    // Blank mask updates on the same edge as the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (w_finish) begin
            r_blank <= w_blankNext;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

    // Status comes straight from the registered state, so busy and done
    // are mutually exclusive and glitch free.
    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign bcd  = r_bcd;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_ctrl
// Directed self-checking bench for bcd_conv_ctrl (WIDTH=8, DIGITS=3).
// Expected BCD and blank values come from decimal division in the bench.
// Blank expectations follow BCD_LZB_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_bcd_conv_ctrl;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;

    int checkCount;
    int failCount;

    bcd_conv_ctrl #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference BCD built from decimal digits.
    function automatic logic [11:0] refBcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference blank mask from the decimal value.
    function automatic logic [2:0] refBlank(input int v);
`ifdef BCD_LZB_EN
        logic [2:0] m;
        m    = 3'b000;
        m[2] = (v < 100);
        m[1] = (v < 10);
        return m;
`else
        return 3'b000;
`endif
    endfunction

    function automatic logic [2:0] resetBlank();
`ifdef BCD_LZB_EN
        return 3'b110;
`else
        return 3'b000;
`endif
    endfunction

    // Present a request on the falling edge; returns #1 after the sampling edge.
    task automatic applyStimulus(input int v, input bit hold);
        @(negedge clk);
        bin   = WIDTH'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Step edges until done, bounded; counts busy samples and flags overlap.
    task automatic waitDone(output int cycles, output int busyCnt);
        cycles  = 0;
        busyCnt = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busyCnt++;
            if (busy === 1'b1 && done === 1'b1) checkOutput("busy_done_overlap", 1, 0);
            @(posedge clk);
            #1;
            cycles++;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        int cycles;
        int busyCnt;
        int doneSeen;

        checkCount = 0;
        failCount  = 0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy",  32'(busy),  0);
        checkOutput("reset_done",  32'(done),  0);
        checkOutput("reset_bcd",   32'(bcd),   0);
        checkOutput("reset_blank", 32'(blank), 32'(resetBlank()));
        @(negedge clk);
        rst = 1'b0;

        // bin = 0
        applyStimulus(0, 0);
        waitDone(cycles, busyCnt);
        checkOutput("zero_latency", cycles, 8);
        checkOutput("zero_bcd",     32'(bcd),   32'h000);
        checkOutput("zero_blank",   32'(blank), 32'(refBlank(0)));

        // bin = 255, full-scale, busy for exactly WIDTH cycles
        applyStimulus(255, 0);
        waitDone(cycles, busyCnt);
        checkOutput("max_latency", cycles, 8);
        checkOutput("max_busy",    busyCnt, 8);
        checkOutput("max_bcd",     32'(bcd),   32'h255);
        checkOutput("max_blank",   32'(blank), 32'(refBlank(255)));
        checkOutput("max_busy_at_done", 32'(busy), 0);
        @(posedge clk);
        #1;
        checkOutput("max_done_pulse", 32'(done), 0);
        checkOutput("max_bcd_hold",   32'(bcd),  32'h255);

        // Back-to-back: 99 then 7 with start held through DONE
        applyStimulus(99, 1);
        bin = WIDTH'(7);
        waitDone(cycles, busyCnt);
        checkOutput("b2b_first_latency", cycles, 8);
        checkOutput("b2b_first_bcd",     32'(bcd),   32'h099);
        checkOutput("b2b_first_blank",   32'(blank), 32'(refBlank(99)));
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_restart_busy", 32'(busy), 1);
        waitDone(cycles, busyCnt);
        checkOutput("b2b_spacing",       cycles + 1, 9);
        checkOutput("b2b_second_bcd",    32'(bcd),   32'h007);
        checkOutput("b2b_second_blank",  32'(blank), 32'(refBlank(7)));

        // Request while busy is dropped
        applyStimulus(128, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bin   = WIDTH'(200);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = WIDTH'(0);
        waitDone(cycles, busyCnt);
        checkOutput("drop_latency", cycles + 4, 8);
        checkOutput("drop_bcd",     32'(bcd), 32'h128);
        doneSeen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkOutput("drop_no_second", doneSeen, 0);

        // Reset mid-conversion aborts without a done pulse
        applyStimulus(173, 0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy",  32'(busy),  0);
        checkOutput("abort_done",  32'(done),  0);
        checkOutput("abort_bcd",   32'(bcd),   0);
        checkOutput("abort_blank", 32'(blank), 32'(resetBlank()));
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        applyStimulus(173, 0);
        waitDone(cycles, busyCnt);
        checkOutput("retry_bcd", 32'(bcd), 32'h173);

        // Full sweep against the decimal model
        for (int v = 0; v < 256; v++) begin
            applyStimulus(v, 0);
            waitDone(cycles, busyCnt);
            checkOutput($sformatf("sweep_bcd_%0d", v),   32'(bcd),   32'(refBcd(v)));
            checkOutput($sformatf("sweep_blank_%0d", v), 32'(blank), 32'(refBlank(v)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
